mmu_req_arbiter: RTL
====================

// Module: mmu_req_arbiter
// PURPOSE
//  Shares the single MMU/cache request port (rd_req/wr_req + rd_valid/wr_done) between NUM_REQ requesters
//  (req 0 = instruction fetch, req 1 = load/store). One transaction outstanding at a time; round-robin grant;
//  routes the MMU response back to the owning requester; watchdog aborts a transaction that never completes.
// PARAMETERS
//  NUM_REQ      2    number of requesters (2..4); per-requester buses below are flattened [NUM_REQ*W-1:0]
//  TIMEOUT      1023 cycles to wait for rd_valid/wr_done before abort; 0 disables watchdog
// PORTS
//  mmu_clk        in   1          single clock for the whole block
//  i_rstn         in   1          asynchronous active-low reset
//  req_rd         in   NUM_REQ    per-requester read request, level, held until req_ack
//  req_wr         in   NUM_REQ    per-requester write request, level, held until req_ack
//  req_addr       in   32*NUM_REQ byte address
//  req_wdata      in   32*NUM_REQ write data
//  req_reg        in   5*NUM_REQ  destination register tag (reads)
//  req_func3      in   3*NUM_REQ  load func3 tag (reads)
//  req_ack        out  NUM_REQ    1-cycle pulse: request accepted, payload may change next cycle
//  rsp_rd_valid   out  NUM_REQ    1-cycle pulse: read data returned to that requester
//  rsp_wr_done    out  NUM_REQ    1-cycle pulse: write complete
//  rsp_err        out  NUM_REQ    1-cycle pulse: watchdog abort
//  rsp_rd_data    out  32         shared read data, valid with rsp_rd_valid
//  rsp_rd_reg     out  5          shared register tag, valid with rsp_rd_valid
//  rsp_rd_func3   out  3          shared func3 tag, valid with rsp_rd_valid
//  rd_req, wr_req out  1          1-cycle pulse to MMU
//  rd_addr, wr_addr out 32        MMU addresses (registered, held through transaction)
//  wr_data        out  32         MMU write data (registered)
//  rd_req_reg     out  5          MMU read register tag
//  rd_req_func3   out  3          MMU read func3 tag
//  rd_data        in   32         MMU read data
//  rd_valid       in   1          MMU read response pulse
//  rd_valid_reg   in   5          MMU returned register tag
//  rd_valid_func3 in   3          MMU returned func3 tag
//  wr_done        in   1          MMU write completion pulse
//  busy           out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = 0, owner = 0, timer = 0.
//  FSM IDLE -> ISSUE -> RD_WAIT | WR_WAIT -> IDLE.
//  IDLE: candidates = requesters with req_rd|req_wr. Grant first candidate at or after rr pointer (wrapping).
//   Latch owner, addr, wdata, reg, func3. Pulse req_ack[owner]. Advance rr = owner+1 mod NUM_REQ. Go to ISSUE.
//  Same requester with both req_rd and req_wr high: read wins; write remains pending for a later grant.
//  ISSUE (1 cycle, one cycle after grant): pulse rd_req or wr_req with registered payload. Clear timer.
//   Go to RD_WAIT or WR_WAIT.
//  RD_WAIT: on rd_valid, copy rd_data/rd_valid_reg/rd_valid_func3 to rsp_rd_*, pulse rsp_rd_valid[owner]
//   in the same cycle (combinational steer; data regs hold until next response). Go to IDLE.
//  WR_WAIT: on wr_done, pulse rsp_wr_done[owner]. Go to IDLE.
//  Watchdog: timer increments each WAIT cycle. If TIMEOUT != 0 and timer == TIMEOUT with no response,
//   pulse rsp_err[owner] and go to IDLE. Timer saturates; no wrap.
//  Response and timeout in the same cycle: the response wins; no error.
//  rd_valid or wr_done in IDLE/ISSUE, or wrong type in WAIT: ignored and dropped, no pulse to any requester.
//  Best-case latency: grant to MMU request is 1 cycle; a new grant is possible the cycle after return to IDLE.
//  Reset asserted mid-transaction: immediately return to IDLE with outputs 0. Any in-flight MMU response is
//   dropped.
//  req_* payload is sampled only in the IDLE grant cycle. Deasserting before req_ack is legal; the request
//   is withdrawn.
// TESTING
//  Reset: i_rstn low mid-RD_WAIT -> all outputs 0, busy=0; late rd_valid after release produces no rsp pulse.
//  Single read: req_rd[1]=1, addr 0x100, reg 5, func3 2 -> req_ack[1] at T, rd_req at T+1 with addr 0x100;
//   rd_valid data 0xDEADBEEF -> rsp_rd_valid[1] with rsp_rd_data 0xDEADBEEF, reg 5, func3 2.
//  Round robin: req_rd[0] and req_rd[1] held continuously -> grants alternate 0,1,0,1; no requester is granted
//   twice in a row.
//  Write: req_wr[0]=1, addr 0x40, data 0x12345678 -> wr_req pulse with these values; wr_done -> rsp_wr_done[0]
//   only.
//  Timeout: TIMEOUT=8, no rd_valid -> rsp_err[owner] 8 cycles after the ISSUE cycle, then IDLE.
//   With rd_valid on cycle 8 -> rsp_rd_valid and no rsp_err.
//  Stray response: wr_done pulsed in IDLE and in RD_WAIT -> no rsp_* pulse and no state change.

Source files
------------

// File: rtl/mmu_req_arbiter_if.sv
// Requester and MMU port bundle for mmu_req_arbiter.
// master = arbiter side, slave = requesters plus MMU model.
interface mmu_req_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_rd;
  logic [NUM_REQ-1:0]    req_wr;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [5*NUM_REQ-1:0]  req_reg;
  logic [3*NUM_REQ-1:0]  req_func3;
  logic [NUM_REQ-1:0]    req_ack;
  logic [NUM_REQ-1:0]    rsp_rd_valid;
  logic [NUM_REQ-1:0]    rsp_wr_done;
  logic [NUM_REQ-1:0]    rsp_err;
  logic [31:0]           rsp_rd_data;
  logic [4:0]            rsp_rd_reg;
  logic [2:0]            rsp_rd_func3;
  logic                  rd_req;
  logic                  wr_req;
  logic [31:0]           rd_addr;
  logic [31:0]           wr_addr;
  logic [31:0]           wr_data;
  logic [4:0]            rd_req_reg;
  logic [2:0]            rd_req_func3;
  logic [31:0]           rd_data;
  logic                  rd_valid;
  logic [4:0]            rd_valid_reg;
  logic [2:0]            rd_valid_func3;
  logic                  wr_done;
  logic                  busy;

  modport master (
    input  req_rd, req_wr, req_addr, req_wdata,
    input  req_reg, req_func3,
    output req_ack, rsp_rd_valid, rsp_wr_done, rsp_err,
    output rsp_rd_data, rsp_rd_reg, rsp_rd_func3,
    output rd_req, wr_req, rd_addr, wr_addr, wr_data,
    output rd_req_reg, rd_req_func3,
    input  rd_data, rd_valid, rd_valid_reg,
    input  rd_valid_func3, wr_done,
    output busy
  );

  modport slave (
    output req_rd, req_wr, req_addr, req_wdata,
    output req_reg, req_func3,
    input  req_ack, rsp_rd_valid, rsp_wr_done, rsp_err,
    input  rsp_rd_data, rsp_rd_reg, rsp_rd_func3,
    input  rd_req, wr_req, rd_addr, wr_addr, wr_data,
    input  rd_req_reg, rd_req_func3,
    output rd_data, rd_valid, rd_valid_reg,
    output rd_valid_func3, wr_done,
    input  busy
  );
endinterface

// File: rtl/mmu_req_arbiter.sv
// Round-robin arbiter sharing one MMU request port between requesters,
// one transaction in flight, with a response watchdog.
module mmu_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1023
) (
  input logic mmu_clk,
  input logic i_rstn,
  mmu_req_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    IDLE, ISSUE, RD_WAIT, WR_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0] rr_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] grant;
  logic          found;
  logic          do_grant;
  logic          is_rd_q;
  logic [TW-1:0] timer_q;
  logic          waiting;
  logic          rd_hit;
  logic          wr_hit;
  logic          tmo;
  int            idx;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] grant_oh;

  logic [31:0] addr_a  [NUM_REQ];
  logic [31:0] wdata_a [NUM_REQ];
  logic [4:0]  reg_a   [NUM_REQ];
  logic [2:0]  func3_a [NUM_REQ];

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  reg_q;
  logic [2:0]  func3_q;
  logic [31:0] rsp_data_q;
  logic [4:0]  rsp_reg_q;
  logic [2:0]  rsp_func3_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = bus.req_addr[32*g +: 32];
    assign wdata_a[g] = bus.req_wdata[32*g +: 32];
    assign reg_a[g]   = bus.req_reg[5*g +: 5];
    assign func3_a[g] = bus.req_func3[3*g +: 3];
  end

  // first candidate at or after the rr pointer, wrapping
  always_comb begin
    cand  = bus.req_rd | bus.req_wr;
    grant = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && cand[IW'(idx)]) begin
        found = 1'b1;
        grant = IW'(idx);
      end
    end
  end

  assign do_grant = (state_q == IDLE) && found;
  assign waiting  = (state_q == RD_WAIT) || (state_q == WR_WAIT);
  assign rd_hit   = (state_q == RD_WAIT) && bus.rd_valid;
  assign wr_hit   = (state_q == WR_WAIT) && bus.wr_done;
  assign tmo      = (TIMEOUT != 0) && waiting &&
                    (timer_q == TW'(TIMEOUT));
  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign grant_oh = NUM_REQ'(1) << grant;

  always_comb begin
    state_d          = state_q;
    bus.req_ack      = '0;
    bus.rsp_rd_valid = '0;
    bus.rsp_wr_done  = '0;
    bus.rsp_err      = '0;
    bus.rd_req       = 1'b0;
    bus.wr_req       = 1'b0;
    bus.rsp_rd_data  = rsp_data_q;
    bus.rsp_rd_reg   = rsp_reg_q;
    bus.rsp_rd_func3 = rsp_func3_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          if (i_rstn) bus.req_ack = grant_oh;
        end
      end
      ISSUE: begin
        bus.rd_req = is_rd_q;
        bus.wr_req = !is_rd_q;
        state_d    = is_rd_q ? RD_WAIT : WR_WAIT;
      end
      RD_WAIT: begin
        if (rd_hit) begin
          bus.rsp_rd_valid = owner_oh;
          bus.rsp_rd_data  = bus.rd_data;
          bus.rsp_rd_reg   = bus.rd_valid_reg;
          bus.rsp_rd_func3 = bus.rd_valid_func3;
          state_d          = IDLE;
        end else if (tmo) begin
          bus.rsp_err = owner_oh;
          state_d     = IDLE;
        end
      end
      WR_WAIT: begin
        if (wr_hit) begin
          bus.rsp_wr_done = owner_oh;
          state_d         = IDLE;
        end else if (tmo) begin
          bus.rsp_err = owner_oh;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      is_rd_q     <= 1'b0;
      timer_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      reg_q       <= '0;
      func3_q     <= '0;
      rsp_data_q  <= '0;
      rsp_reg_q   <= '0;
      rsp_func3_q <= '0;
    end else begin
      state_q <= state_d;
      // timer counts cycles since the ISSUE cycle began
      if (do_grant) begin
        owner_q <= grant;
        is_rd_q <= bus.req_rd[grant];
        addr_q  <= addr_a[grant];
        wdata_q <= wdata_a[grant];
        reg_q   <= reg_a[grant];
        func3_q <= func3_a[grant];
        rr_q    <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        timer_q <= '0;
      end else if (state_q != IDLE && timer_q != '1) begin
        timer_q <= timer_q + 1'b1;
      end
      if (rd_hit) begin
        rsp_data_q  <= bus.rd_data;
        rsp_reg_q   <= bus.rd_valid_reg;
        rsp_func3_q <= bus.rd_valid_func3;
      end
    end
  end

  assign bus.rd_addr      = addr_q;
  assign bus.wr_addr      = addr_q;
  assign bus.wr_data      = wdata_q;
  assign bus.rd_req_reg   = reg_q;
  assign bus.rd_req_func3 = func3_q;
  assign bus.busy         = (state_q != IDLE);

endmodule
